// File: rtl/arith_pkg.sv
// Shared types and helpers for the iterative multiplier.
//   state_e     : controller states (idle / calculating / result held)
//   MaxW        : width of the helper functions' working vectors; callers
//                 zero-extend into it and slice the low bits back out
//   cond_negate : two's-complement negate when neg is set (MaxW wrap)
//   magnitude   : |v| of a w-bit value when is_signed, else v unchanged
package arith_pkg;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  localparam int unsigned MaxW = 128;

  function automatic logic [MaxW-1:0] cond_negate(input logic [MaxW-1:0] v, input logic neg);
    return neg ? (~v + MaxW'(1)) : v;
  endfunction

  // For w-bit -2^(w-1) the low w bits of the result are 2^(w-1): the
  // magnitude fits unsigned in w bits, so no overflow case exists.
  function automatic logic [MaxW-1:0] magnitude(input logic [MaxW-1:0] v, input int unsigned w,
                                                input logic is_signed);
    return cond_negate(v, is_signed & v[w-1]);
  endfunction

endpackage

// File: rtl/arith_nbits_seq_mul_dpath.sv
// Datapath of the iterative multiplier: operand magnitudes, shifted
// multiplicand, accumulator, step counter and final sign fix-up.
//   clk, reset     : clock, synchronous active-high reset (clears all state)
//   load           : capture in0/in1/in_signed and clear accumulator/counter
//   step           : perform one shift-add bit step
//   in0, in1       : multiplicand / multiplier
//   in_signed      : operands are two's complement when set
//   last           : current step is step NBITS-1 (final one)
//   b_next_zero    : multiplier becomes zero after the current step
//   result         : accumulator with sign applied (2*NBITS wrap)
// Legal NBITS: 2 .. 63 (limited by arith_pkg::MaxW).
module arith_nbits_seq_mul_dpath
  import arith_pkg::*;
#(
  parameter int unsigned NBITS = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [NBITS-1:0]   in0,
  input  logic [NBITS-1:0]   in1,
  input  logic               in_signed,
  output logic               last,
  output logic               b_next_zero,
  output logic [2*NBITS-1:0] result
);

  localparam int unsigned PW = 2 * NBITS;
  localparam int unsigned CW = $clog2(NBITS) + 1;

  logic [MaxW-1:0]  mag0_full, mag1_full, res_full;
  logic [PW-1:0]    a_q, acc_q;
  logic [NBITS-1:0] b_q, b_next;
  logic [CW-1:0]    cnt_q;
  logic             neg_q;
  logic             unused_hi;

  assign mag0_full = magnitude(MaxW'(in0), NBITS, in_signed);
  assign mag1_full = magnitude(MaxW'(in1), NBITS, in_signed);
  assign res_full  = cond_negate(MaxW'(acc_q), neg_q);
  assign result    = res_full[PW-1:0];

  assign unused_hi = ^{mag0_full[MaxW-1:NBITS], mag1_full[MaxW-1:NBITS], res_full[MaxW-1:PW]};

  assign b_next      = b_q >> 1;
  assign b_next_zero = (b_next == '0);
  assign last        = (cnt_q == CW'(NBITS - 1));

  // a_q is shifted left each step instead of shifting by cnt_q, which gives
  // the same addend without a barrel shifter.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
    end else if (load) begin
      a_q   <= PW'(mag0_full[NBITS-1:0]);
      b_q   <= mag1_full[NBITS-1:0];
      acc_q <= '0;
      cnt_q <= '0;
      neg_q <= in_signed & (in0[NBITS-1] ^ in1[NBITS-1]);
    end else if (step) begin
      acc_q <= acc_q + (b_q[0] ? a_q : '0);
      a_q   <= a_q << 1;
      b_q   <= b_next;
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/arith_nbits_seq_mul.sv
// Iterative signed/unsigned NBITS x NBITS -> 2*NBITS multiplier with
// val/rdy handshakes; one radix-2 shift-add step per cycle.
//   clk, reset      : clock, synchronous active-high reset
//   in_val/in_rdy   : request handshake; in0, in1, in_signed captured on transfer
//   out_val/out_rdy : response handshake; out held while out_val && !out_rdy
//   out             : product, zero while no result is presented
// Build option ARITH_NBITS_SEQ_MUL_EARLY_EXIT_EN: leave the calculate state as
// soon as the remaining multiplier bits are all zero (same results, fewer
// cycles for small multipliers). Default build always takes NBITS steps.
module arith_nbits_seq_mul
  import arith_pkg::*;
#(
  parameter int unsigned NBITS = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_val,
  output logic               in_rdy,
  input  logic [NBITS-1:0]   in0,
  input  logic [NBITS-1:0]   in1,
  input  logic               in_signed,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [2*NBITS-1:0] out
);

`ifdef ARITH_NBITS_SEQ_MUL_EARLY_EXIT_EN
  localparam bit EarlyExit = 1'b1;
`else
  localparam bit EarlyExit = 1'b0;
`endif

  state_e             state_q;
  logic               load, step, last, b_next_zero;
  logic [2*NBITS-1:0] result;

  assign load = in_val & in_rdy;
  assign step = (state_q == StCalc);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: if (load) state_q <= StCalc;
        StCalc: if (last || (EarlyExit && b_next_zero)) state_q <= StDone;
        StDone: if (out_rdy) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs are decoded from held state only; reset forces them inactive
  // in the same cycle since state updates only on the following edge.
  assign in_rdy  = ~reset & (state_q == StIdle);
  assign out_val = ~reset & (state_q == StDone);
  assign out     = out_val ? result : '0;

  arith_nbits_seq_mul_dpath #(
    .NBITS(NBITS)
  ) u_dpath (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .step       (step),
    .in0        (in0),
    .in1        (in1),
    .in_signed  (in_signed),
    .last       (last),
    .b_next_zero(b_next_zero),
    .result     (result)
  );

endmodule

// File: tb/tb_arith_nbits_seq_mul.sv
module tb_arith_nbits_seq_mul;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        in_val8 = 0, in_rdy8, sgn8 = 0, out_val8, out_rdy8 = 1;
  logic [7:0]  in0_8 = 0, in1_8 = 0;
  logic [15:0] out8;
  logic        in_val13 = 0, in_rdy13, sgn13 = 0, out_val13, out_rdy13 = 1;
  logic [12:0] in0_13 = 0, in1_13 = 0;
  logic [25:0] out13;

  int n_checks = 0;
  int n_fail = 0;

  arith_nbits_seq_mul #(.NBITS(8)) dut8 (
    .clk(clk), .reset(reset), .in_val(in_val8), .in_rdy(in_rdy8), .in0(in0_8), .in1(in1_8),
    .in_signed(sgn8), .out_val(out_val8), .out_rdy(out_rdy8), .out(out8)
  );

  arith_nbits_seq_mul #(.NBITS(13)) dut13 (
    .clk(clk), .reset(reset), .in_val(in_val13), .in_rdy(in_rdy13), .in0(in0_13),
    .in1(in1_13), .in_signed(sgn13), .out_val(out_val13), .out_rdy(out_rdy13), .out(out13)
  );

`ifdef ARITH_NBITS_SEQ_MUL_EARLY_EXIT_EN
  localparam bit EarlyExit = 1'b1;
`else
  localparam bit EarlyExit = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: full-precision integer product, truncated to 2w bits.
  function automatic logic [63:0] ref_prod(input int w, input logic [63:0] a, input logic [63:0] b,
                                           input logic s);
    longint x, y, m;
    m = (longint'(1) << w) - 1;
    x = longint'(a) & m;
    y = longint'(b) & m;
    if (s && x >= (longint'(1) << (w - 1))) x = x - (longint'(1) << w);
    if (s && y >= (longint'(1) << (w - 1))) y = y - (longint'(1) << w);
    return 64'((x * y) & ((longint'(1) << (2 * w)) - 1));
  endfunction

  // Expected number of calculate cycles.
  function automatic int ref_lat(input int w, input logic [63:0] b, input logic s);
    longint y, m;
    int hi;
    if (!EarlyExit) return w;
    m = (longint'(1) << w) - 1;
    y = longint'(b) & m;
    if (s && y >= (longint'(1) << (w - 1))) y = (longint'(1) << w) - y;
    hi = 0;
    for (int i = 0; i < w; i++) if (y[i]) hi = i + 1;
    return (hi == 0) ? 1 : hi;
  endfunction

  task automatic drive(input int w, input logic v, input logic [63:0] a, input logic [63:0] b,
                       input logic s);
    if (w == 8) begin
      in_val8 = v; in0_8 = a[7:0]; in1_8 = b[7:0]; sgn8 = s;
    end else begin
      in_val13 = v; in0_13 = a[12:0]; in1_13 = b[12:0]; sgn13 = s;
    end
  endtask

  function automatic logic get_rdy(input int w);
    return (w == 8) ? in_rdy8 : in_rdy13;
  endfunction
  function automatic logic get_val(input int w);
    return (w == 8) ? out_val8 : out_val13;
  endfunction
  function automatic logic [63:0] get_out(input int w);
    return (w == 8) ? 64'(out8) : 64'(out13);
  endfunction

  task automatic set_ordy(input int w, input logic r);
    if (w == 8) out_rdy8 = r; else out_rdy13 = r;
  endtask

  // One transaction: transfer, latency, result, optional backpressure, release.
  // Called and returns at a negedge.
  task automatic run(input string tag, input int w, input logic [63:0] a, input logic [63:0] b,
                     input logic s, input logic [63:0] exp, input int hold);
    int k;
    logic rdy_leak;
    logic [63:0] first;
    drive(w, 1'b1, a, b, s);
    set_ordy(w, hold == 0);
    k = 0;
    while (!get_rdy(w) && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_in_rdy"}, 64'(get_rdy(w)), 64'(1));
    @(negedge clk);
    // Scramble inputs after transfer; the captured values must be used.
    drive(w, 1'b0, 64'($urandom), 64'($urandom), ~s);
    k = 1;
    rdy_leak = 1'b0;
    while (!get_val(w) && k < 200) begin
      if (get_rdy(w)) rdy_leak = 1'b1;
      @(negedge clk);
      k++;
    end
    check({tag, "_latency"}, 64'(k), 64'(ref_lat(w, b, s) + 1));
    check({tag, "_busy_rdy"}, 64'(rdy_leak), 64'(0));
    check({tag, "_out"}, get_out(w), exp);
    first = get_out(w);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_val"}, 64'(get_val(w)), 64'(1));
      check({tag, "_hold_out"}, get_out(w), first);
      check({tag, "_hold_rdy"}, 64'(get_rdy(w)), 64'(0));
    end
    set_ordy(w, 1'b1);
    @(negedge clk);
    check({tag, "_after_rdy"}, 64'(get_rdy(w)), 64'(1));
    check({tag, "_after_val"}, 64'(get_val(w)), 64'(0));
  endtask

  initial begin
    logic [63:0] ra, rb;
    logic rs;
    logic val_seen;

    // Reset behaviour
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_rdy", 64'(in_rdy8), 64'(0));
    check("rst_out_val", 64'(out_val8), 64'(0));
    check("rst_out", 64'(out8), 64'(0));
    reset = 1'b0;
    @(negedge clk);
    check("idle_in_rdy", 64'(in_rdy8), 64'(1));
    check("idle_out_val", 64'(out_val8), 64'(0));

    // Directed signed / unsigned
    run("s_2x3", 8, 64'h02, 64'h03, 1'b1, 64'h0006, 0);
    run("s_m2x2", 8, 64'hFE, 64'h02, 1'b1, 64'hFFFC, 0);
    run("s_m12xm13", 8, 64'hF4, 64'hF3, 1'b1, 64'h009C, 0);
    run("s_m128xm128", 8, 64'h80, 64'h80, 1'b1, 64'h4000, 0);
    run("u_128x2", 8, 64'h80, 64'h02, 1'b0, 64'h0100, 0);
    run("s_ffxff", 8, 64'hFF, 64'hFF, 1'b1, 64'h0001, 0);
    // Backpressure for 5 cycles
    run("u_255x255_bp", 8, 64'hFF, 64'hFF, 1'b0, 64'hFE01, 5);

    // Reset in third calculate cycle aborts the transaction
    drive(8, 1'b1, 64'h37, 64'h55, 1'b0);
    @(negedge clk);
    drive(8, 1'b0, 64'h0, 64'h0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_rst_val", 64'(out_val8), 64'(0));
    check("abort_rst_rdy", 64'(in_rdy8), 64'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    val_seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_val8) val_seen = 1'b1;
    end
    check("abort_no_val", 64'(val_seen), 64'(0));
    run("s_100xm99", 8, 64'h64, 64'h9D, 1'b1, 64'hD954, 0);

    // Early-exit sensitive operands (latency from the reference either way)
    run("s_20x1", 8, 64'h14, 64'h01, 1'b1, 64'h0014, 0);
    run("s_20x0", 8, 64'h14, 64'h00, 1'b1, 64'h0000, 0);
    run("s_20xm16", 8, 64'h14, 64'hF0, 1'b1, 64'hFEC0, 0);

    // Random pairs, both widths
    for (int i = 0; i < 20; i++) begin
      ra = 64'($urandom);
      rb = 64'($urandom);
      rs = 1'($urandom);
      if (i % 5 == 0) rb = rb & 64'h3;
      run("rnd8", 8, ra, rb, rs, ref_prod(8, ra, rb, rs), (i % 7 == 0) ? 2 : 0);
    end
    for (int i = 0; i < 20; i++) begin
      ra = 64'($urandom);
      rb = 64'($urandom);
      rs = 1'($urandom);
      if (i % 5 == 0) rb = rb & 64'h1F;
      if (i == 1) begin ra = 64'h1000; rb = 64'h1000; rs = 1'b1; end
      run("rnd13", 13, ra, rb, rs, ref_prod(13, ra, rb, rs), (i % 7 == 0) ? 3 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arith_nbits_seq_mul.md
# arith_nbits_seq_mul

Parametrised, iterative two's-complement/unsigned multiplier. Successor to the combinational 8-bit signed multiplier: arbitrary operand width, a per-transaction signed/unsigned mode, and latency-insensitive val/rdy interfaces. One product bit-step per cycle (radix-2 shift-add on magnitudes, sign fix-up at the end). Sits in the arithmetic library as the area-cheap alternative to the single-cycle multipliers.

## Interface
- NBITS, 8, operand width; product is 2*NBITS; legal NBITS >= 2
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- in_val  input  1  request valid
- in_rdy  output  1  block can accept a request
- in0  input  NBITS  multiplicand
- in1  input  NBITS  multiplier
- in_signed  input  1  1 = treat in0/in1 as two's complement; 0 = unsigned
- out_val  output  1  product valid
- out_rdy  input  1  consumer can accept product
- out  output  2*NBITS  product (two's complement if in_signed was 1)

## Operation
- States: IDLE, CALC, DONE (enum in package).
- IDLE: in_rdy=1. On in_val && in_rdy: latch a=|in0|, b=|in1| (magnitudes only when in_signed=1, else raw), neg = in_signed & (in0[MSB] ^ in1[MSB]), clear 2*NBITS accumulator and counter; go CALC.
- CALC: each cycle, if b[0] then acc += a (a zero-extended, shifted left by counter); b >>= 1; counter++. After NBITS cycles go DONE.
- DONE: out = neg ? -acc : acc (2*NBITS wrap arithmetic); out_val=1. On out_rdy go IDLE.
- Magnitude of -2^(NBITS-1) is 2^(NBITS-1), held unsigned in NBITS bits; no overflow: -128*-128 (NBITS=8) = 0x4000.
- Signed result exactly equals sign-extended full-precision product; unsigned result equals zero-extended product.
- Operands/mode captured at transfer; input changes afterward have no effect.
- in_rdy=0 in CALC and DONE; no request overlap.
- out holds stable while out_val=1 and out_rdy=0.

## Timing
- Reset: state=IDLE on next edge; while reset=1, in_rdy=0, out_val=0, out=0. Reset in CALC/DONE aborts the transaction; the product is discarded.
- Transfer in cycle t -> CALC cycles t+1..t+NBITS -> out_val=1 from cycle t+NBITS+1.
- DONE with out_rdy=1 in cycle d -> IDLE in d+1, in_rdy=1 in d+1. Back-to-back throughput: one result per NBITS+2 cycles.
- out is registered/decoded from state-held values only; no combinational path from in_* or out_rdy to out. in_rdy and out_val depend on state only (and reset).

## Configuration
- ARITH_NBITS_SEQ_MUL_EARLY_EXIT_EN defined: CALC also exits to DONE at the end of any cycle in which the shifted b becomes zero; latency = max(1, index of highest set bit of |in1| + 1) CALC cycles. b=0 -> one CALC cycle. Results identical.
- Undefined: fixed NBITS CALC cycles regardless of operands.

## Structure
- arith_pkg: state enum typedef (IDLE/CALC/DONE), shared magnitude/negate helper functions.
- Sub-module arith_nbits_seq_mul_dpath: operand/accumulator/counter registers, adder, negation; top holds FSM and handshake control.
- Counter width $clog2(NBITS)+1.

## Test plan (NBITS=8 unless noted)
- Reset then idle: in_rdy=0 during reset, 1 after; out_val=0 throughout.
- Signed 2*3, -2*2, -12*-13, -128*-128 -> 0x0006, 0xFFFC, 0x009C, 0x4000; out_val first at transfer+9 cycles (macro undefined).
- Unsigned 255*255, 128*2 -> 0xFE01, 0x0100; same operand bits signed 0xFF*0xFF -> 0x0001.
- Backpressure: out_rdy=0 for 5 cycles in DONE -> out_val and out stable, in_rdy=0; then out_rdy=1 -> in_rdy=1 next cycle.
- Reset asserted in third CALC cycle -> no out_val; next transaction 100*-99 -> 0xD954.
- Early-exit build: 20*1 -> out_val at transfer+2; 20*0 -> 0x0000 at transfer+2; 20*-16 -> 0xFEC0 at transfer+6; 20 random signed/unsigned pairs match full-width reference product, with NBITS=8 and NBITS=13 both run.
